// File: rtl/nes_joypad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : nes_joypad_responder
//  Purpose  : Makes the board behave like a standard NES controller (a 4021
//             parallel-in/serial-out shift register) on the console-side pins.
//             Board push buttons are synchronised and debounced. They are then
//             shifted out serially in response to the console's latch and
//             clock strobes.
//  Ports    : clk            - system clock
//             rst            - synchronous, active-high reset
//             btn_n_in[7:0]  - raw buttons, active-low, asynchronous
//                              [0]A [1]B [2]SELECT [3]START
//                              [4]UP [5]DOWN [6]LEFT [7]RIGHT
//             jp_latch_in    - console latch strobe, async, active-high
//             jp_clk_in      - console shift clock, async, rising edge shifts
//             jp_data_out    - serial data (0 = pressed or fill, 1 = released)
//             btn_state_out  - debounced buttons, active-high, same bit order
//             shift_cnt_out  - shifts since the last latch, saturates at 8
//  Revision : 1.0 - initial release
// ============================================================================
module nes_joypad_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_n_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out,
  output logic [3:0] shift_cnt_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // --------------------------------------------------------------------------
  // Input synchronisers. Stage 0 captures the pin, and the last stage is the
  // synced value. The reset values match the idle levels of the pins, so
  // leaving reset never produces a false edge.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][7:0] btn_sync;
  logic [SYNC_STAGES-1:0]      latch_sync;
  logic [SYNC_STAGES-1:0]      jclk_sync;
  logic                        latch_d;
  logic                        jclk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync   <= '1;
      latch_sync <= '0;
      jclk_sync  <= '0;
      latch_d    <= 1'b0;
      jclk_d     <= 1'b0;
    end else begin
      btn_sync   <= {btn_sync[SYNC_STAGES-2:0], btn_n_in};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], jp_latch_in};
      jclk_sync  <= {jclk_sync[SYNC_STAGES-2:0], jp_clk_in};
      latch_d    <= latch_sync[SYNC_STAGES-1];
      jclk_d     <= jclk_sync[SYNC_STAGES-1];
    end
  end

  logic       latch_s;
  logic       latch_fall;
  logic       jclk_rise;
  logic [7:0] pressed_s;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign latch_fall = ~latch_s & latch_d;
  assign jclk_rise  = jclk_sync[SYNC_STAGES-1] & ~jclk_d;
  assign pressed_s  = ~btn_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Per-button debounce. The counter only runs while the synced level differs
  // from the accepted level. The accepted level flips on the cycle where a
  // difference is seen with the counter already at DEBOUNCE_CYCLES-1. A change
  // therefore has to persist for DEBOUNCE_CYCLES synced samples before it is
  // accepted.
  // --------------------------------------------------------------------------
  logic [7:0] btn_state;

  for (genvar i = 0; i < 8; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             accepted;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt      <= '0;
        accepted <= 1'b0;
      end else if (pressed_s[i] == accepted) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        accepted <= ~accepted;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign btn_state[i] = accepted;
  end

  // --------------------------------------------------------------------------
  // Shift register. It holds electrical levels, so a pressed button is 0.
  // While the latch is high, the register continuously follows the debounced
  // buttons. Because the latch test has priority, a clock edge that coincides
  // with the latch is ignored. On the cycle the latch falls the register only
  // holds its value. Each rising edge of the console clock after that shifts
  // right, filling with 0.
  // --------------------------------------------------------------------------
  logic [7:0] sr;
  logic [3:0] shift_cnt;
  logic       data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= 8'hFF;
      shift_cnt <= 4'd0;
      data_q    <= 1'b1;
    end else begin
      if (latch_s) begin
        sr        <= ~btn_state;
        shift_cnt <= 4'd0;
      end else if (latch_fall) begin
        sr <= sr;
      end else if (jclk_rise) begin
        sr <= {1'b0, sr[7:1]};
        if (shift_cnt != 4'd8) begin
          shift_cnt <= shift_cnt + 4'd1;
        end
      end
      data_q <= sr[0];
    end
  end

  assign jp_data_out   = data_q;
  assign btn_state_out = btn_state;
  assign shift_cnt_out = shift_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nes_joypad_responder
//  Purpose  : Self-checking bench for nes_joypad_responder. It uses directed
//             scenarios followed by randomised frames. The expected values
//             come from a frame-level model: a latch takes a snapshot of the
//             inverted button state, and the k-th read after it returns bit k
//             of that snapshot (or 0 once k >= 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nes_joypad_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_n_in;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic       jp_data_out;
  logic [7:0] btn_state_out;
  logic [3:0] shift_cnt_out;

  int total = 0;
  int bad   = 0;

  // Frame-level reference: the snapshot taken by the last latch (or reset),
  // and the number of console clocks seen since then.
  logic [7:0] snap;
  int         reads;

  nes_joypad_responder #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n_in     (btn_n_in),
    .jp_latch_in  (jp_latch_in),
    .jp_clk_in    (jp_clk_in),
    .jp_data_out  (jp_data_out),
    .btn_state_out(btn_state_out),
    .shift_cnt_out(shift_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_data();
    return (reads < 8) ? snap[reads] : 1'b0;
  endfunction

  function automatic logic [3:0] exp_cnt();
    return (reads > 8) ? 4'd8 : 4'(reads);
  endfunction

  task automatic check_serial(input string tag);
    check({tag, "_data"}, {7'd0, jp_data_out}, {7'd0, exp_data()});
    check({tag, "_cnt"}, {4'd0, shift_cnt_out}, {4'd0, exp_cnt()});
  endtask

  // One console clock pulse. The pulse is long enough to cover the
  // synchroniser, the edge detector and the output register.
  task automatic pulse_clk(input bit counts);
    jp_clk_in = 1'b1;
    tick(3);
    jp_clk_in = 1'b0;
    tick(3);
    if (counts) reads++;
  endtask

  task automatic latch_pulse(input logic [7:0] pressed);
    jp_latch_in = 1'b1;
    tick(6);
    jp_latch_in = 1'b0;
    tick(6);
    snap  = ~pressed;
    reads = 0;
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    // 1. Reset with idle inputs
    rst = 1'b1; btn_n_in = 8'hFF; jp_latch_in = 1'b0; jp_clk_in = 1'b0;
    snap = 8'hFF; reads = 0;
    tick(3);
    check("rst_data", {7'd0, jp_data_out}, 8'h01);
    check("rst_btn", btn_state_out, 8'h00);
    check("rst_cnt", {4'd0, shift_cnt_out}, 8'h00);
    rst = 1'b0;
    tick(1);

    // 2. Debounce latency and glitch rejection
    btn_n_in = 8'hFE;
    tick(6);
    check("deb_latency", btn_state_out, 8'h01);
    tick(4);
    check("deb_hold", btn_state_out, 8'h01);
    btn_n_in = 8'hFC;
    tick(2);
    btn_n_in = 8'hFE;
    tick(10);
    check("deb_glitch", btn_state_out, 8'h01);

    // 3. A+START frame
    btn_n_in = ~8'h09;
    tick(10);
    check("s3_btn", btn_state_out, 8'h09);
    latch_pulse(8'h09);
    check_serial("s3_b0");
    for (int k = 1; k <= 8; k++) begin
      pulse_clk(1'b1);
      check_serial($sformatf("s3_b%0d", k));
    end

    // 4. Extra clocks saturate, then a fresh latch reloads
    for (int k = 0; k < 4; k++) begin
      pulse_clk(1'b1);
      check_serial($sformatf("s4_extra%0d", k));
    end
    latch_pulse(8'h09);
    check_serial("s4_relatch");

    // 5. Latch held high: clocks ignored (one coincides with the latch rise),
    //    and the register follows a button pressed mid-latch.
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    tick(6);
    jp_clk_in = 1'b0;
    tick(3);
    check("s5_cnt_coincide", {4'd0, shift_cnt_out}, 8'h00);
    for (int k = 0; k < 4; k++) pulse_clk(1'b0);
    check("s5_cnt_held", {4'd0, shift_cnt_out}, 8'h00);
    check("s5_data_held", {7'd0, jp_data_out}, 8'h00);
    btn_n_in = ~8'h0B;
    tick(10);
    check("s5_btn", btn_state_out, 8'h0B);
    jp_latch_in = 1'b0;
    tick(6);
    snap  = ~8'h0B;
    reads = 0;
    check_serial("s5_b0");
    for (int k = 1; k <= 3; k++) begin
      pulse_clk(1'b1);
      check_serial($sformatf("s5_b%0d", k));
    end

    // 6. Reset mid-frame, then shift 0s in from all-released
    rst = 1'b1;
    tick(1);
    check("s6_rst_data", {7'd0, jp_data_out}, 8'h01);
    check("s6_rst_cnt", {4'd0, shift_cnt_out}, 8'h00);
    check("s6_rst_btn", btn_state_out, 8'h00);
    rst   = 1'b0;
    snap  = 8'hFF;
    reads = 0;
    for (int k = 1; k <= 9; k++) begin
      pulse_clk(1'b1);
      check_serial($sformatf("s6_b%0d", k));
    end

    // Randomised frames
    for (int it = 0; it < 6; it++) begin
      b        = 8'($urandom_range(0, 255));
      btn_n_in = ~b;
      tick(10);
      check($sformatf("rnd%0d_btn", it), btn_state_out, b);
      latch_pulse(b);
      check_serial($sformatf("rnd%0d_b0", it));
      n = $urandom_range(0, 11);
      for (int k = 1; k <= n; k++) begin
        pulse_clk(1'b1);
        check_serial($sformatf("rnd%0d_b%0d", it, k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
